dram_mch_engine: RTL
====================

DRAM_MCH_ENGINE -- requirements
Module: dram_mch_engine

Interface
REQ-001 Parameter NCH, default 4: number of user request channels, range 1..8.
REQ-002 Parameter DW, default 512: MIG application data width, in bits.
REQ-003 Parameter AW, default 28: MIG application address width.
REQ-004 Parameter ADDR_STEP, default 8: increment added to the address per element.
REQ-005 Parameter LAST_ADDR, default 28'h7FFFFF8: last valid element address; the address wraps to 0 after it.
REQ-006 Parameter MAX_OUTST, default 16: maximum number of issued reads whose data has not yet returned, range 1..64.
REQ-007 Port CLK, input, 1 bit: the single clock, equal to the MIG ui_clk; all logic is in this domain.
REQ-008 Port RST_X, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port CALIB_DONE, input, 1 bit: MIG init_calib_complete.
REQ-010 Port D_REQ, input, 2*NCH bits: per-channel request, 2'b00 = none, 2'b01 = write, 2'b10 = read, 2'b11 = none.
REQ-011 Port D_INITADR, input, 32*NCH bits: per-channel initial address; bits [AW-1:0] are used.
REQ-012 Port D_ELEM, input, 32*NCH bits: per-channel element count.
REQ-013 Port D_DIN, input, DW*NCH bits: per-channel write data.
REQ-014 Port D_W, output, NCH bits: per-channel write-data consume strobe.
REQ-015 Port D_DOUT, output, DW bits: read data, shared by all channels.
REQ-016 Port D_DOUTEN, output, NCH bits: per-channel read-data valid.
REQ-017 Port D_BUSY, output, NCH bits: per-channel busy flag.
REQ-018 Port D_DONE, output, NCH bits: per-channel one-cycle completion pulse.
REQ-019 Ports app_addr (output, AW), app_cmd (output, 3), app_en (output, 1), app_wdf_data (output, DW), app_wdf_wren (output, 1), app_wdf_end (output, 1): MIG application request and write-data ports.
REQ-020 Ports app_rdy (input, 1), app_wdf_rdy (input, 1), app_rd_data (input, DW), app_rd_data_valid (input, 1): MIG application ready and read-data ports.

Function
REQ-021 The state machine SHALL have states IDLE, WRITE, RD_ISSUE and RD_DRAIN.
REQ-022 In IDLE with CALIB_DONE=1, the block SHALL grant one channel with D_REQ of 01 or 10 by round-robin, searching from the channel after the last granted one; after reset the search starts at channel 0.
REQ-023 On grant, the block SHALL latch the channel's D_INITADR, D_ELEM and direction, and set D_BUSY[g]=1 in the following cycle.
REQ-024 D_REQ SHALL be ignored in every state except IDLE, and while CALIB_DONE=0.
REQ-025 A grant with D_ELEM=0 SHALL issue no app_en, SHALL pulse D_DONE[g] one cycle later, and SHALL return the state machine to IDLE.
REQ-026 Write: the next state SHALL be WRITE, with app_cmd=3'b000 and app_en=1 registered.
REQ-027 D_W[g] SHALL equal (state==WRITE && app_rdy && app_wdf_rdy && remain!=0), combinationally.
REQ-028 In each D_W cycle the block SHALL register app_wdf_data from the D_DIN slice of g, set app_wdf_wren=1, advance the address and decrement remain; in all other cycles app_wdf_wren=0.
REQ-029 app_wdf_end SHALL equal app_wdf_wren.
REQ-030 When the last element of a write is accepted, the block SHALL set app_en=0, pulse D_DONE[g] in the next cycle, and return to IDLE.
REQ-031 Read: the next state SHALL be RD_ISSUE, with app_cmd=3'b001.
REQ-032 In RD_ISSUE, app_en SHALL be 1 only while issue_remain>0 and outst<MAX_OUTST.
REQ-033 A read is issued when app_rdy && app_en; each issue SHALL advance the address, decrement issue_remain and increment outst.
REQ-034 When issue_remain reaches 0, the state SHALL move to RD_DRAIN.
REQ-035 Each app_rd_data_valid SHALL register D_DOUT=app_rd_data, assert D_DOUTEN[g]=1 for one cycle, decrement outst and decrement ret_remain.
REQ-036 An issue and a return in the same cycle SHALL leave outst unchanged.
REQ-037 When ret_remain reaches 0, the block SHALL pulse D_DONE[g] and return to IDLE.
REQ-038 Address update: next address SHALL be 0 when addr==LAST_ADDR, else addr+ADDR_STEP truncated to AW bits.
REQ-039 remain counters SHALL be 32 bits and outst SHALL be clog2(MAX_OUTST+1) bits; neither SHALL ever underflow or overflow.
REQ-040 At most one bit of each of D_W, D_DOUTEN, D_BUSY and D_DONE SHALL be set at any time, and only bit g.
REQ-041 D_BUSY[g] SHALL drop in the same cycle that D_DONE[g] pulses.
REQ-042 CALIB_DONE falling mid-transfer SHALL NOT abort the transfer; only new grants are blocked.

Reset
REQ-043 While RST_X=0, asynchronously: state=IDLE; app_en, app_wdf_wren, app_addr, app_cmd, app_wdf_data, D_DOUT, D_DOUTEN, D_BUSY, D_DONE, all counters =0; round-robin pointer at channel 0.
REQ-044 A reset asserted mid-transfer SHALL abandon that transfer without a D_DONE pulse.
REQ-045 Read data returned after reset release for reads issued before reset SHALL be ignored, because state=IDLE.

Verification
REQ-046 Write: ch1 write of INITADR=0x100, ELEM=4, app_rdy toggling -> 4 D_W[1] pulses, app_addr 0x100/0x108/0x110/0x118, D_DONE[1] once.
REQ-047 Read with MAX_OUTST=2, ELEM=5, DRAM latency 20 cycles -> outst never exceeds 2, 5 D_DOUTEN[2] pulses in order, D_DONE[2] after the 5th.
REQ-048 Wrap: INITADR=LAST_ADDR-8, ELEM=3 -> addresses LAST_ADDR-8, LAST_ADDR, 0.
REQ-049 Arbitration: all 4 channels request continuously -> grant order 0,1,2,3,0.
REQ-050 ELEM=0 on ch3 -> no app_en, D_DONE[3] pulse 2 cycles after D_REQ is sampled.
REQ-051 RST_X low during RD_DRAIN -> all outputs 0 immediately; late app_rd_data_valid produces no D_DOUTEN.

Source files
------------

// File: rtl/dram_mch_engine.sv
// Multi-channel front end for a MIG application port: round-robin grants one
// channel at a time and streams its write or read burst element by element.
module dram_mch_engine #(
  parameter int              NCH       = 4,
  parameter int              DW        = 512,
  parameter int              AW        = 28,
  parameter int              ADDR_STEP = 8,
  parameter logic [AW-1:0]   LAST_ADDR = 28'h7FFFFF8,
  parameter int              MAX_OUTST = 16
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic                CALIB_DONE,
  input  logic [2*NCH-1:0]    D_REQ,
  input  logic [32*NCH-1:0]   D_INITADR,
  input  logic [32*NCH-1:0]   D_ELEM,
  input  logic [DW*NCH-1:0]   D_DIN,
  output logic [NCH-1:0]      D_W,
  output logic [DW-1:0]       D_DOUT,
  output logic [NCH-1:0]      D_DOUTEN,
  output logic [NCH-1:0]      D_BUSY,
  output logic [NCH-1:0]      D_DONE,
  output logic [AW-1:0]       app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DW-1:0]       app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic [DW-1:0]       app_rd_data,
  input  logic                app_rd_data_valid
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_DRAIN} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   g, rr_ptr, pick;
  logic            pick_vld, grant, done_now, wr_go, rd_iss, rd_ret;
  logic [1:0]      pick_req;
  logic [31:0]     remain, ret_remain;
  logic [OW-1:0]   outst;
  logic [NCH-1:0]  g_oh, pick_oh;
  logic [AW-1:0]   addr_nx;
  int              idx;

  // Walk channels downward from rr_ptr+NCH-1 so the closest one after rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = NCH-1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (^D_REQ[2*idx +: 2]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_req    = D_REQ[2*pick +: 2];
  assign grant       = (state == IDLE) && CALIB_DONE && pick_vld;
  assign g_oh        = NCH'(1) << g;
  assign pick_oh     = NCH'(1) << pick;
  assign app_en      = ((state == WRITE) && (remain != 32'd0)) ||
                       ((state == RD_ISSUE) && (remain != 32'd0) && (outst < OMAX));
  assign wr_go       = (state == WRITE) && app_rdy && app_wdf_rdy && (remain != 32'd0);
  assign rd_iss      = (state == RD_ISSUE) && app_en && app_rdy;
  // Returns outside a read transfer (e.g. stragglers from before a reset) are dropped.
  assign rd_ret      = app_rd_data_valid && ((state == RD_ISSUE) || (state == RD_DRAIN)) &&
                       (ret_remain != 32'd0) && (outst != '0);
  assign D_W         = wr_go ? g_oh : '0;
  assign app_wdf_end = app_wdf_wren;
  assign addr_nx     = (app_addr == LAST_ADDR) ? '0 : app_addr + AW'(ADDR_STEP);
  assign done_now    = (state != IDLE) && (state_nx == IDLE);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= IDLE;
    else        state <= state_nx;
  end

  // ret_remain == issue_remain + outst, so it only hits 0 in RD_ISSUE for an empty burst.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (grant) state_nx = (pick_req == 2'b01) ? WRITE : RD_ISSUE;
      WRITE:    if ((remain == 32'd0) || (wr_go && (remain == 32'd1))) state_nx = IDLE;
      RD_ISSUE: if (ret_remain == 32'd0) state_nx = IDLE;
                else if (rd_iss && (remain == 32'd1)) state_nx = RD_DRAIN;
      RD_DRAIN: if (rd_ret && (ret_remain == 32'd1)) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      g            <= '0;
      rr_ptr       <= '0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      remain       <= '0;
      ret_remain   <= '0;
      outst        <= '0;
      D_DOUT       <= '0;
      D_DOUTEN     <= '0;
      D_BUSY       <= '0;
      D_DONE       <= '0;
    end else begin
      app_wdf_wren <= wr_go;
      D_DOUTEN     <= rd_ret ? g_oh : '0;
      D_DONE       <= done_now ? g_oh : '0;
      if (grant) begin
        g          <= pick;
        rr_ptr     <= (pick == GW'(NCH-1)) ? '0 : pick + 1'b1;
        app_addr   <= D_INITADR[32*pick +: AW];
        remain     <= D_ELEM[32*pick +: 32];
        ret_remain <= D_ELEM[32*pick +: 32];
        app_cmd    <= (pick_req == 2'b01) ? 3'b000 : 3'b001;
        D_BUSY     <= pick_oh;
      end else if (done_now) begin
        D_BUSY     <= '0;
      end
      if (wr_go) begin
        app_wdf_data <= D_DIN[DW*g +: DW];
        app_addr     <= addr_nx;
        remain       <= remain - 32'd1;
      end
      if (rd_iss) begin
        app_addr <= addr_nx;
        remain   <= remain - 32'd1;
      end
      if (rd_ret) begin
        D_DOUT     <= app_rd_data;
        ret_remain <= ret_remain - 32'd1;
      end
      case ({rd_iss, rd_ret})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
